// File: rtl/icache_refill_unit_pkg.sv
// rtl/icache_refill_unit_pkg.sv - shared icache refill defaults and FSM state type
// Contents:
//   DEF_N_WAY, DEF_SET_WIDTH, DEF_WORD_SIZE, DEF_ADDR_WIDTH : default geometry
//   refill_state_e                                          : refill FSM states
package icache_refill_unit_pkg;

  localparam int DEF_N_WAY      = 4;
  localparam int DEF_SET_WIDTH  = 128;
  localparam int DEF_WORD_SIZE  = 64;
  localparam int DEF_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FILL  = 2'd2,
    WRITE = 2'd3
  } refill_state_e;

endpackage

// File: rtl/icache_refill_unit_victim_sel.sv
// rtl/icache_refill_unit_victim_sel.sv - victim way selection (lowest invalid way, else round-robin)
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   way_valid_i   : valid bits of the missed set
//   advance_i     : step the round-robin pointer (completed write that used it)
//   victim_o      : selected way
//   use_rr_o      : high when victim_o came from the round-robin pointer
module icache_victim_sel
  import icache_refill_unit_pkg::*;
#(
  parameter int N_WAY = DEF_N_WAY,
  parameter int WAY_W = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_WAY-1:0] way_valid_i,
  input  logic             advance_i,
  output logic [WAY_W-1:0] victim_o,
  output logic             use_rr_o
);

  logic [WAY_W-1:0] r_ptr;
  logic [WAY_W-1:0] w_free_idx;
  logic             w_has_free;

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    w_has_free = 1'b0;
    w_free_idx = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (!way_valid_i[i]) begin
        w_has_free = 1'b1;
        w_free_idx = WAY_W'(i);
      end
    end
  end

  assign victim_o = w_has_free ? w_free_idx : r_ptr;
  assign use_rr_o = !w_has_free;

  // Explicit wrap so non-power-of-two way counts stay in range.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr <= '0;
    end else if (advance_i) begin
      r_ptr <= (r_ptr == WAY_W'(N_WAY - 1)) ? '0 : r_ptr + WAY_W'(1);
    end
  end

endmodule

// File: rtl/icache_refill_unit.sv
// rtl/icache_refill_unit.sv - instruction cache line refill: fetch, assemble, write victim way
// Optional feature macro: ICACHE_REFILL_ERR_EN (adds mem_rsp_err_i / refill_err_o)
// Ports:
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   miss_valid_i/miss_ready_o    : miss handshake; miss_idx_i set index, miss_way_valid_i set valid bits
//   kill_i                       : abort the refill in progress
//   mem_req_valid_o/ready_i      : line fetch request, mem_req_idx_o set index
//   mem_rsp_valid_i/data_i       : response beats, lowest word first
//   ram_req_o/we_o/addr_o/data_o : one-cycle line write toward the data array
//   refill_done_o/refill_way_o   : completion pulse and way written
//   busy_o                       : refill in progress
//   mem_rsp_err_i/refill_err_o   : (ICACHE_REFILL_ERR_EN) beat error in, error pulse out
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int N_WAY      = DEF_N_WAY,
  parameter int SET_WIDTH  = DEF_SET_WIDTH,
  parameter int WORD_SIZE  = DEF_WORD_SIZE,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  localparam int WAY_W     = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] miss_idx_i,
  input  logic [N_WAY-1:0]      miss_way_valid_i,
  input  logic                  kill_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_idx_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [WORD_SIZE-1:0]  mem_rsp_data_i,
  output logic [N_WAY-1:0]      ram_req_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [SET_WIDTH-1:0]  ram_data_o,
  output logic                  refill_done_o,
  output logic [WAY_W-1:0]      refill_way_o,
  output logic                  busy_o
`ifdef ICACHE_REFILL_ERR_EN
  ,
  input  logic                  mem_rsp_err_i,
  output logic                  refill_err_o
`endif
);

  localparam int BEATS = SET_WIDTH / WORD_SIZE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  refill_state_e r_state;
  refill_state_e w_state_nxt;

  logic [ADDR_WIDTH-1:0] r_idx;
  logic [WAY_W-1:0]      r_victim;
  logic                  r_use_rr;
  logic [BW-1:0]         r_beat;
  logic                  r_killed;
  logic [SET_WIDTH-1:0]  r_line;

  logic [WAY_W-1:0]      w_victim;
  logic                  w_use_rr;
  logic                  w_advance;
  logic                  w_last_beat;
  logic                  w_drop;
  logic [N_WAY-1:0]      w_way_onehot;

  icache_victim_sel #(
    .N_WAY (N_WAY),
    .WAY_W (WAY_W)
  ) u_victim_sel (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .way_valid_i (miss_way_valid_i),
    .advance_i   (w_advance),
    .victim_o    (w_victim),
    .use_rr_o    (w_use_rr)
  );

  assign w_last_beat  = mem_rsp_valid_i && (r_beat == LAST_BEAT);
  assign w_way_onehot = N_WAY'(1) << r_victim;
  // The pointer only moves when the write it chose actually lands.
  assign w_advance    = (r_state == WRITE) && r_use_rr && !rst_i;

`ifdef ICACHE_REFILL_ERR_EN
  logic r_err;
  logic w_err_beat;

  assign w_err_beat   = (r_state == FILL) && mem_rsp_valid_i && mem_rsp_err_i;
  // A kill or error arriving with the final beat still cancels the write.
  assign w_drop       = r_killed || kill_i || r_err || w_err_beat;
  assign refill_err_o = (r_state == FILL) && w_last_beat && (r_err || mem_rsp_err_i) && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (r_state == IDLE) begin
      r_err <= 1'b0;
    end else if (w_err_beat) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_drop = r_killed || kill_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    miss_ready_o    = 1'b0;
    mem_req_valid_o = 1'b0;
    ram_req_o       = '0;
    ram_we_o        = 1'b0;
    refill_done_o   = 1'b0;
    refill_way_o    = '0;
    case (r_state)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        if (kill_i) begin
          w_state_nxt = IDLE;
        end else if (mem_req_ready_i) begin
          w_state_nxt = FILL;
        end
      end
      FILL: begin
        if (w_last_beat) begin
          w_state_nxt = w_drop ? IDLE : WRITE;
        end
      end
      WRITE: begin
        w_state_nxt = IDLE;
        // Reset in the write cycle suppresses the write itself.
        if (!rst_i) begin
          ram_req_o     = w_way_onehot;
          ram_we_o      = 1'b1;
          refill_done_o = 1'b1;
          refill_way_o  = r_victim;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_idx    <= '0;
      r_victim <= '0;
      r_use_rr <= 1'b0;
      r_beat   <= '0;
      r_killed <= 1'b0;
      r_line   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (miss_valid_i) begin
            r_idx    <= miss_idx_i;
            r_victim <= w_victim;
            r_use_rr <= w_use_rr;
            r_killed <= 1'b0;
            r_beat   <= '0;
          end
        end
        REQ: begin
          if (!kill_i && mem_req_ready_i) begin
            r_beat <= '0;
          end
        end
        FILL: begin
          if (kill_i) begin
            r_killed <= 1'b1;
          end
          if (mem_rsp_valid_i) begin
            for (int k = 0; k < BEATS; k++) begin
              if (r_beat == BW'(k)) begin
                r_line[k*WORD_SIZE +: WORD_SIZE] <= mem_rsp_data_i;
              end
            end
            r_beat <= w_last_beat ? '0 : r_beat + BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req_idx_o = r_idx;
  assign ram_addr_o    = r_idx;
  assign ram_data_o    = r_line;
  assign busy_o        = (r_state != IDLE);

endmodule

// File: tb/tb_icache_refill_unit.sv
// tb/tb_icache_refill_unit.sv - randomized self-checking bench for icache_refill_unit
module tb_icache_refill_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_valid;
  logic         miss_ready;
  logic [7:0]   miss_idx;
  logic [3:0]   miss_way_valid;
  logic         kill;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [7:0]   mem_req_idx;
  logic         mem_rsp_valid;
  logic [63:0]  mem_rsp_data;
  logic [3:0]   ram_req;
  logic         ram_we;
  logic [7:0]   ram_addr;
  logic [127:0] ram_data;
  logic         refill_done;
  logic [1:0]   refill_way;
  logic         busy;
`ifdef ICACHE_REFILL_ERR_EN
  logic         mem_rsp_err;
  logic         refill_err;
`endif

  always #5 clk = ~clk;

  icache_refill_unit dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .miss_valid_i     (miss_valid),
    .miss_ready_o     (miss_ready),
    .miss_idx_i       (miss_idx),
    .miss_way_valid_i (miss_way_valid),
    .kill_i           (kill),
    .mem_req_valid_o  (mem_req_valid),
    .mem_req_ready_i  (mem_req_ready),
    .mem_req_idx_o    (mem_req_idx),
    .mem_rsp_valid_i  (mem_rsp_valid),
    .mem_rsp_data_i   (mem_rsp_data),
    .ram_req_o        (ram_req),
    .ram_we_o         (ram_we),
    .ram_addr_o       (ram_addr),
    .ram_data_o       (ram_data),
    .refill_done_o    (refill_done),
    .refill_way_o     (refill_way),
    .busy_o           (busy)
`ifdef ICACHE_REFILL_ERR_EN
    ,
    .mem_rsp_err_i    (mem_rsp_err),
    .refill_err_o     (refill_err)
`endif
  );

  typedef struct {
    int           way;
    logic [7:0]   idx;
    logic [127:0] data;
    int           cyc;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  int  cyc   = 0;
  int  ptr   = 0;
  int  last_way = -1;
  int  last_wr_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Scoreboard: every write-side activity must match the next expected write.
  always @(negedge clk) begin
    if (ram_we || refill_done || ram_req != 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {ram_we, refill_done, ram_req}, 6'b0);
      end else begin
        wr_t e;
        logic [3:0] oh;
        e  = exp_q.pop_front();
        oh = 4'b0001 << e.way;
        chk("wr_we", ram_we, 1'b1);
        chk("wr_done", refill_done, 1'b1);
        chk("wr_req_onehot", ram_req, oh);
        chk("wr_way", refill_way, e.way[1:0]);
        chk("wr_addr", ram_addr, e.idx);
        chk("wr_data", ram_data, e.data);
        chk("wr_cycle", cyc, e.cyc);
        last_way    = int'(refill_way);
        last_wr_cyc = cyc;
      end
    end
  end

  // kmode: 0 none, 1 kill in REQ, 2 kill in FILL after beat 0, 3 kill in IDLE, 4 kill in WRITE
  task automatic refill(input logic [7:0] idx, input logic [3:0] wv, input int stall,
                        input int kmode, input int gap, input bit err1,
                        input logic [63:0] b0, input logic [63:0] b1, output int lat);
    int  vic;
    bit  use_rr;
    bit  dropped;
    int  t0;
    logic [63:0] b[2];
    b[0] = b0;
    b[1] = b1;
    lat  = -1;
    use_rr = 1'b1;
    vic    = ptr;
    for (int i = 0; i < 4; i++) begin
      if (!wv[i] && use_rr) begin
        vic    = i;
        use_rr = 1'b0;
      end
    end
    miss_valid = 1'b1; miss_idx = idx; miss_way_valid = wv; kill = (kmode == 3);
    @(negedge clk);
    chk("accept_ready", miss_ready, 1'b1);
    chk("accept_busy", busy, 1'b0);
    t0 = cyc;
    @(posedge clk); #1;
    miss_valid = 1'b0; miss_idx = 8'($urandom); miss_way_valid = 4'($urandom); kill = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      mem_req_ready = (s == stall);
      mem_rsp_valid = 1'($urandom);
      mem_rsp_data  = rand64();
      if (kmode == 1 && s == 0) kill = 1'b1;
      @(negedge clk);
      chk("req_valid", mem_req_valid, 1'b1);
      chk("req_idx", mem_req_idx, idx);
      chk("req_not_ready", miss_ready, 1'b0);
      @(posedge clk); #1;
      kill = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      if (kmode == 1) begin
        @(negedge clk);
        chk("kill_req_valid_drop", mem_req_valid, 1'b0);
        chk("kill_req_idle", miss_ready, 1'b1);
        @(posedge clk); #1;
        return;
      end
    end
    dropped = (kmode == 2) || err1;
    for (int k = 0; k < 2; k++) begin
      int g;
      g = (gap > 0) ? $urandom_range(0, gap) : 0;
      for (int j = 0; j < g; j++) begin
        mem_rsp_valid = 1'b0; mem_rsp_data = rand64();
        @(negedge clk);
        chk("fill_busy", busy, 1'b1);
        chk("fill_no_req", mem_req_valid, 1'b0);
        @(posedge clk); #1;
      end
      mem_rsp_valid = 1'b1; mem_rsp_data = b[k];
`ifdef ICACHE_REFILL_ERR_EN
      mem_rsp_err = err1 && (k == 1);
`endif
      @(negedge clk);
`ifdef ICACHE_REFILL_ERR_EN
      if (k == 1) chk("err_pulse", refill_err, err1);
      else chk("err_quiet", refill_err, 1'b0);
`endif
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
      mem_rsp_err = 1'b0;
`endif
      if (kmode == 2 && k == 0) begin
        kill = 1'b1;
        @(negedge clk);
        chk("kill_fill_busy", busy, 1'b1);
        @(posedge clk); #1;
        kill = 1'b0;
      end
    end
    if (!dropped) begin
      exp_q.push_back('{vic, idx, {b[1], b[0]}, cyc});
      if (kmode == 4) kill = 1'b1;
      @(negedge clk);
      lat = cyc - t0;
      @(posedge clk); #1;
      kill = 1'b0;
      if (use_rr) ptr = (ptr + 1) % 4;
    end else begin
      @(negedge clk);
      chk("drop_idle_ready", miss_ready, 1'b1);
      chk("drop_no_done", refill_done, 1'b0);
      @(posedge clk); #1;
    end
  endtask

  int lat;
  int kmodes[7] = '{0, 0, 0, 1, 2, 3, 4};
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    #500000;
    $display("FAIL watchdog timeout cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; miss_valid = 1'b0; miss_idx = '0; miss_way_valid = '0; kill = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
`ifdef ICACHE_REFILL_ERR_EN
    mem_rsp_err = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_miss_ready", miss_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_ram_data", ram_data, 128'h0);
    chk("rst_way", refill_way, 2'd0);
    @(posedge clk); #1;

    // Directed line assembly and minimum latency
    refill(8'h3A, 4'b1011, 0, 0, 0, 1'b0, {16{4'h1}}, {16{4'h2}}, lat);
    chk("lat_min", lat, 4);
    chk("way_first_invalid", last_way, 2);

    // Round-robin over a fully valid set
    for (int i = 0; i < 5; i++) begin
      refill(8'($urandom), 4'hF, 0, 0, 0, 1'b0, rand64(), rand64(), lat);
      chk("rr_way", last_way, rr_exp[i]);
    end

    // Request stall keeps request stable
    refill(8'hC5, 4'b0111, 3, 0, 0, 1'b0, rand64(), rand64(), lat);
    chk("lat_stall3", lat, 7);

    // Kill variants
    refill(8'h11, 4'hF, 0, 2, 0, 1'b0, rand64(), rand64(), lat);
    refill(8'h12, 4'hF, 2, 1, 0, 1'b0, rand64(), rand64(), lat);
    refill(8'h13, 4'hF, 0, 3, 0, 1'b0, rand64(), rand64(), lat);
    chk("kill_idle_ignored", last_way, 1);
    refill(8'h14, 4'hF, 1, 4, 1, 1'b0, rand64(), rand64(), lat);
    chk("kill_write_late", last_way, 2);

    // Reset in the middle of FILL
    miss_valid = 1'b1; miss_idx = 8'h55; miss_way_valid = 4'hF;
    @(posedge clk); #1;
    miss_valid = 1'b0; mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = rand64();
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_no_we", ram_we, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = rand64();
    @(negedge clk);
    chk("midrst_ready", miss_ready, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_req_valid", mem_req_valid, 1'b0);
    chk("midrst_req_idx", mem_req_idx, 8'h0);
    chk("midrst_ram_addr", ram_addr, 8'h0);
    chk("midrst_ram_data", ram_data, 128'h0);
    chk("midrst_done", refill_done, 1'b0);
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("midrst_beat_ignored_busy", busy, 1'b0);
    chk("midrst_beat_ignored_line", ram_data, 128'h0);
    @(posedge clk); #1;
    ptr = 0;
    refill(8'h77, 4'hF, 0, 0, 0, 1'b0, rand64(), rand64(), lat);
    chk("ptr_after_reset", last_way, 0);

`ifdef ICACHE_REFILL_ERR_EN
    refill(8'h66, 4'hF, 0, 0, 0, 1'b1, rand64(), rand64(), lat);
`endif

    // Randomized refills
    for (int n = 0; n < 40; n++) begin
      logic [3:0] wv;
      int km;
      bit e1;
      wv = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom);
      km = kmodes[$urandom_range(0, 6)];
      e1 = 1'b0;
`ifdef ICACHE_REFILL_ERR_EN
      if (km == 0 && $urandom_range(0, 4) == 0) e1 = 1'b1;
`endif
      refill(8'($urandom), wv, $urandom_range(0, 3), km, 2, e1, rand64(), rand64(), lat);
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_unit.md
ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

Interface
REQ-001 SHALL have parameters N_WAY (4, number of ways), SET_WIDTH (128, line bits), WORD_SIZE (64, memory beat bits), ADDR_WIDTH (8, set index bits).
REQ-002 SHALL have these ports, clock and reset first:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- miss_valid_i  in  1  miss request
- miss_ready_o  out  1  miss accepted when high with miss_valid_i
- miss_idx_i  in  ADDR_WIDTH  set index of miss
- miss_way_valid_i  in  N_WAY  valid bits of the missed set
- kill_i  in  1  abort current refill
- mem_req_valid_o  out  1  line fetch request
- mem_req_ready_i  in  1  memory accepts request
- mem_req_idx_o  out  ADDR_WIDTH  requested set index
- mem_rsp_valid_i  in  1  response beat valid
- mem_rsp_data_i  in  WORD_SIZE  response beat
- ram_req_o  out  N_WAY  one-hot way enable toward data memory
- ram_we_o  out  1  write enable toward data memory
- ram_addr_o  out  ADDR_WIDTH  write set index
- ram_data_o  out  SET_WIDTH  assembled line
- refill_done_o  out  1  one-cycle completion pulse
- refill_way_o  out  log2(N_WAY)  way written, valid with refill_done_o
- busy_o  out  1  high whenever not IDLE
REQ-003 Clock is clk_i; reset is rst_i, synchronous, active-high; no other clock or reset.

Function
REQ-004 FSM states IDLE, REQ, FILL, WRITE; miss_ready_o SHALL equal (state==IDLE).
REQ-005 IDLE->REQ on miss_valid_i; latch miss_idx_i and victim way in same cycle.
REQ-006 Victim SHALL be lowest-index way with miss_way_valid_i bit 0; if all ones, round-robin pointer value.
REQ-007 Round-robin pointer SHALL advance by 1 modulo N_WAY only on a completed write that used it; wraps N_WAY-1->0.
REQ-008 REQ: mem_req_valid_o=1, mem_req_idx_o=latched index, held stable until mem_req_ready_i; handshake moves to FILL with beat counter 0.
REQ-009 FILL: each mem_rsp_valid_i beat k (k=0..SET_WIDTH/WORD_SIZE-1) SHALL be stored at line bits [k*WORD_SIZE +: WORD_SIZE]; beats without valid ignored; after last beat -> WRITE.
REQ-010 WRITE lasts exactly one cycle: ram_req_o=one-hot victim, ram_we_o=1, ram_addr_o=latched index, ram_data_o=line; refill_done_o=1 and refill_way_o=victim same cycle; next state IDLE.
REQ-011 Outside WRITE, ram_req_o, ram_we_o, refill_done_o SHALL be 0; ram_addr_o/ram_data_o don't-care but deterministic (hold last).
REQ-012 Minimum miss-accept to write latency: 1 (REQ) + beats + 1 cycles with zero memory stall; 4 cycles for defaults.
REQ-013 kill_i in REQ: drop mem_req_valid_o next cycle, go IDLE, no write; kill_i in IDLE: ignored.
REQ-014 kill_i in FILL: mark line killed, keep consuming remaining beats, then return IDLE without WRITE, no done pulse, pointer unchanged.
REQ-015 kill_i in WRITE: write still completes (kill too late).
REQ-016 Response beats in IDLE/REQ/WRITE SHALL be ignored.

Reset
REQ-017 rst_i high at any clock edge, including mid-refill: state IDLE, beat counter 0, pointer 0, kill flag 0, line register 0; all outputs 0 except miss_ready_o=1.
REQ-018 No ram write SHALL occur in the cycle rst_i is sampled high.

Configuration
REQ-019 Macro ICACHE_REFILL_ERR_EN: when defined, adds input mem_rsp_err_i (1) and output refill_err_o (1).
REQ-020 With it: err on any valid beat behaves as kill (drain, no write) and refill_err_o pulses one cycle on final beat; without it: ports absent, errors not modelled.

Structure
REQ-021 N_WAY, SET_WIDTH, WORD_SIZE, ADDR_WIDTH defaults and the FSM state enum SHALL live in the shared icache package.
REQ-022 Victim selection (priority-invalid plus round-robin pointer) SHALL be sub-module icache_victim_sel; rest flat.

Verification
REQ-023 Idx 0x3A, way_valid 0b1011, zero stall, beats 0x1111..., 0x2222... -> WRITE cycle 4: ram_req_o=0b0100, addr 0x3A, data {0x2222...,0x1111...}, refill_way_o=2.
REQ-024 Five refills with way_valid 0b1111 -> ways 0,1,2,3,0; pointer wraps.
REQ-025 mem_req_ready_i low 3 cycles -> mem_req_valid_o and idx stable throughout; done at cycle 7.
REQ-026 kill_i after beat 0 -> beat 1 consumed, no ram_we_o, no done, next miss accepted next cycle.
REQ-027 rst_i in FILL -> next cycle all outputs 0, miss_ready_o=1; later beat ignored.
REQ-028 With ICACHE_REFILL_ERR_EN, err on beat 1 -> refill_err_o pulse, no write; without macro build compiles without ports.
